// File: rtl/main_memory_arbiter_pkg.sv
// Shared core types for the main memory arbiter: request record, FSM states,
// requester identifiers and the default cache line width.
// No logic; imported by the arbiter top and its round-robin sub-module.
package main_memory_arbiter_pkg;

  // Default icache line width in bits.
  localparam int ICACHE_LINE_WIDTH = 128;

  typedef struct packed {
    logic [31:0]                  addr;
    logic                         is_store;
    logic [ICACHE_LINE_WIDTH-1:0] data;
  } memory_request_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } requester_id_e;

endpackage

// File: rtl/main_memory_arbiter_rr_arbiter_2.sv
// Purpose: two-way round-robin grant between icache and dcache requesters.
// Latency: grant is combinational; the last-grant pointer updates on the clock edge when advance is high.
// Backpressure: none; the caller decides when a grant is consumed via advance.
// Ports: clock/reset, req_ic/req_dc (raw requests), advance (grant consumed),
//        gnt_vld/gnt_id (current winner).
module rr_arbiter_2
  import main_memory_arbiter_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          req_ic,
  input  logic          req_dc,
  input  logic          advance,
  output logic          gnt_vld,
  output requester_id_e gnt_id
);

  requester_id_e last_q;

  always_comb begin
    gnt_vld = req_ic | req_dc;
    gnt_id  = REQ_IC;
    if (req_ic && req_dc) begin
      // Tie: the requester that did not win last time gets the grant.
      gnt_id = (last_q == REQ_DC) ? REQ_IC : REQ_DC;
    end else if (req_dc) begin
      gnt_id = REQ_DC;
    end
  end

  // Pointer starts at dcache so the icache wins the first tie after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_q <= REQ_DC;
    end else if (advance && gnt_vld) begin
      last_q <= gnt_id;
    end
  end

endmodule

// File: rtl/main_memory_arbiter.sv
// Purpose: arbitrates icache/dcache miss traffic onto a single main-memory port, one transaction in flight.
// Latency: mem_req_valid one cycle after req_valid; rsp_valid one cycle after mem_rsp_valid.
// Backpressure: holds the request in ISSUE while mem_req_ready is low; requesters hold req_valid until their response.
// Ports: clock/reset; ic_req_*/ic_rsp_* and dc_req_*/dc_rsp_* cache sides;
//        mem_req_*/mem_rsp_* memory side; busy (not IDLE); timeout_err (sticky watchdog).
module main_memory_arbiter
  import main_memory_arbiter_pkg::*;
#(
  parameter int LINE_WIDTH     = ICACHE_LINE_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ic_req_valid,
  input  memory_request_t       ic_req_info,
  output logic                  ic_rsp_valid,
  output logic [LINE_WIDTH-1:0] ic_rsp_data,
  input  logic                  dc_req_valid,
  input  memory_request_t       dc_req_info,
  output logic                  dc_rsp_valid,
  output logic [LINE_WIDTH-1:0] dc_rsp_data,
  output logic                  mem_req_valid,
  output memory_request_t       mem_req_info,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  input  logic [LINE_WIDTH-1:0] mem_rsp_data,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e       state;
  memory_request_t  req_q;
  requester_id_e    owner_q;
  logic [CNT_W-1:0] wait_cnt;

  logic             gnt_vld;
  requester_id_e    gnt_id;
  logic [LINE_WIDTH-1:0] rsp_line;

  rr_arbiter_2 u_rr (
    .clock   (clock),
    .reset   (reset),
    .req_ic  (ic_req_valid),
    .req_dc  (dc_req_valid),
    .advance (state == ST_IDLE),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  // Stores complete with an all-zero line regardless of what memory returns.
  always_comb begin
    rsp_line = req_q.is_store ? '0 : mem_rsp_data;
  end

  assign mem_req_info = req_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      req_q         <= '0;
      owner_q       <= REQ_IC;
      wait_cnt      <= '0;
      mem_req_valid <= 1'b0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
      ic_rsp_valid  <= 1'b0;
      ic_rsp_data   <= '0;
      dc_rsp_valid  <= 1'b0;
      dc_rsp_data   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            req_q         <= (gnt_id == REQ_DC) ? dc_req_info : ic_req_info;
            owner_q       <= gnt_id;
            mem_req_valid <= 1'b1;
            busy          <= 1'b1;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            wait_cnt      <= '0;
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
          // Trips on the edge that takes the count to TIMEOUT_CYCLES; keeps waiting.
          if (wait_cnt >= CNT_TRIP) begin
            timeout_err <= 1'b1;
          end
          if (mem_rsp_valid) begin
            if (owner_q == REQ_IC) begin
              ic_rsp_valid <= 1'b1;
              ic_rsp_data  <= rsp_line;
            end else begin
              dc_rsp_valid <= 1'b1;
              dc_rsp_data  <= rsp_line;
            end
            state <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          ic_rsp_valid <= 1'b0;
          ic_rsp_data  <= '0;
          dc_rsp_valid <= 1'b0;
          dc_rsp_data  <= '0;
          busy         <= 1'b0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/main_memory_arbiter.md
MAIN_MEMORY_ARBITER -- requirements
Module: main_memory_arbiter

Interface
REQ-001 SHALL take parameter LINE_WIDTH, default `ICACHE_LINE_WIDTH (128), the cache line width in bits.
REQ-002 SHALL take parameter TIMEOUT_CYCLES, default 64, the WAIT-state cycle count at which the watchdog error sets.
REQ-003 SHALL have port clock  in  1  the single clock; all flops rise-edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low (asserted = 0).
REQ-005 SHALL have port ic_req_valid  in  1  icache miss request, held high until ic_rsp_valid.
REQ-006 SHALL have port ic_req_info  in  memory_request_t  icache request (addr, is_store=0).
REQ-007 SHALL have port ic_rsp_valid  out  1  one-cycle response pulse to icache.
REQ-008 SHALL have port ic_rsp_data  out  LINE_WIDTH  line returned to icache.
REQ-009 SHALL have port dc_req_valid  in  1  dcache miss/writeback request, held until dc_rsp_valid.
REQ-010 SHALL have port dc_req_info  in  memory_request_t  dcache request (addr, is_store, data).
REQ-011 SHALL have port dc_rsp_valid  out  1  one-cycle response pulse to dcache.
REQ-012 SHALL have port dc_rsp_data  out  LINE_WIDTH  line returned to dcache.
REQ-013 SHALL have port mem_req_valid  out  1  request to main memory.
REQ-014 SHALL have port mem_req_info  out  memory_request_t  latched winner request.
REQ-015 SHALL have port mem_req_ready  in  1  memory accepts request when high with mem_req_valid.
REQ-016 SHALL have port mem_rsp_valid  in  1  memory response strobe.
REQ-017 SHALL have port mem_rsp_data  in  LINE_WIDTH  memory response line.
REQ-018 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-019 SHALL have port timeout_err  out  1  sticky watchdog flag.

Function
REQ-020 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE, one transaction outstanding at most.
REQ-021 IDLE: if any req_valid, SHALL grant one requester, latch its req_info and owner, go to ISSUE next cycle; else stay.
REQ-022 Arbitration SHALL be round-robin: on simultaneous requests the requester not granted last wins; a lone requester always wins.
REQ-023 After reset, last-grant SHALL point to dcache so icache wins the first tie.
REQ-024 ISSUE: mem_req_valid=1, mem_req_info=latched request; on mem_req_ready=1 SHALL go to WAIT next cycle.
REQ-025 WAIT: on mem_rsp_valid=1 SHALL latch mem_rsp_data (load) or zero (store) and go to RESPOND.
REQ-026 RESPOND: exactly the owner's rsp_valid SHALL be 1 for one cycle with latched data; then IDLE.
REQ-027 Minimum latency SHALL be: req_valid in cycle t, mem_req_valid in t+1, rsp_valid one cycle after mem_rsp_valid.
REQ-028 req_valid SHALL NOT be sampled in ISSUE, WAIT or RESPOND; drops of req_valid after grant SHALL not abort the transaction.
REQ-029 mem_rsp_valid outside WAIT SHALL be ignored; mem_req_valid SHALL be 0 outside ISSUE.
REQ-030 Non-owner rsp_valid SHALL stay 0; rsp_data SHALL be 0 whenever its rsp_valid is 0.
REQ-031 A cycle counter SHALL clear on WAIT entry, increment each WAIT cycle, saturate; at TIMEOUT_CYCLES timeout_err SHALL set and stay set until reset; FSM keeps waiting.

Reset
REQ-032 Reset assertion SHALL asynchronously force IDLE, last-grant=dcache, counter=0, timeout_err=0, all valids and data outputs 0, including mid-transaction; the in-flight transaction is dropped.
REQ-033 Release SHALL be synchronous-safe: first arbitration in the first clock edge with reset=1.

Structure
REQ-034 memory_request_t, the FSM state enum and the requester-id enum SHALL live in the shared core package; LINE_WIDTH default SHALL come from the shared defines.
REQ-035 The round-robin grant logic SHALL be a sub-module, rr_arbiter_2.

Verification
REQ-036 Lone icache load addr 0x100, memory ready immediately, response after 10 cycles with 0xA5.. -> single ic_rsp_valid pulse, ic_rsp_data=0xA5.., dc outputs 0.
REQ-037 ic and dc request same cycle after reset -> icache served first, dcache second with no idle gap beyond one IDLE cycle; third tie goes to icache.
REQ-038 dcache store addr 0x200 data 0x5A.. -> mem_req_info carries is_store=1 and data; dc_rsp_valid pulses with dc_rsp_data=0.
REQ-039 mem_req_ready low 5 cycles in ISSUE -> mem_req_valid/info held stable all 5 cycles; spurious mem_rsp_valid during ISSUE ignored.
REQ-040 No response for 64 WAIT cycles -> timeout_err=1 at cycle 64, stays 1 after late response completes normally.
REQ-041 Reset asserted in WAIT -> immediately busy=0, all outputs 0; later mem_rsp_valid ignored.
